// File: rtl/team_06_volume_shifter.sv
// Registered digital volume control: scales an 8-bit sample by (volume+1)/16 or bypasses it.
// Optional build macro TEAM06_VOLUME_CENTERED_EN scales offset-binary samples about the midpoint instead of toward 0.
module team_06_volume_shifter #(
  parameter int AUDIO_W = 8,
  parameter int VOL_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic [VOL_W-1:0]   volume,
  input  logic               enable_volume,
  output logic [AUDIO_W-1:0] audio_out
);

  localparam int PROD_W = AUDIO_W + VOL_W + 1;
  localparam int MULT_W = VOL_W + 1;
  localparam logic [AUDIO_W-1:0] MIDPOINT = {1'b1, {(AUDIO_W-1){1'b0}}};

  logic [MULT_W-1:0]  mult_val;
  logic [PROD_W-1:0]  operand_ext;
  logic [PROD_W-1:0]  partial [MULT_W];
  logic [PROD_W-1:0]  product;
  logic [AUDIO_W-1:0] scaled;
  logic [AUDIO_W-1:0] audio_out_next;
  logic [AUDIO_W-1:0] audio_out_reg;
  logic               unused_bits;

  assign mult_val = {1'b0, volume} + MULT_W'(1);

`ifdef TEAM06_VOLUME_CENTERED_EN
  // Flipping the MSB turns offset-binary into two's complement (in - midpoint); sign-extend it.
  assign operand_ext = {{(PROD_W-AUDIO_W){~audio_in[AUDIO_W-1]}},
                        ~audio_in[AUDIO_W-1], audio_in[AUDIO_W-2:0]};
`else
  assign operand_ext = {{(PROD_W-AUDIO_W){1'b0}}, audio_in};
`endif

  generate
    for (genvar gi = 0; gi < MULT_W; gi++) begin : g_partial
      assign partial[gi] = mult_val[gi] ? (operand_ext << gi) : '0;
    end
  endgenerate

  always_comb begin
    product = '0;
    for (int i = 0; i < MULT_W; i++) begin
      product = product + partial[i];
    end
  end

  // Dropping the low VOL_W bits is a floor shift for both unsigned and two's-complement
  // products, and the gain never exceeds 1, so the next AUDIO_W bits hold the whole result.
`ifdef TEAM06_VOLUME_CENTERED_EN
  assign scaled = product[VOL_W +: AUDIO_W] + MIDPOINT;
`else
  assign scaled = product[VOL_W +: AUDIO_W];
`endif

  assign unused_bits = ^{product[VOL_W-1:0], product[PROD_W-1]};

  always_comb begin
    audio_out_next = audio_in;
    if (enable_volume) begin
      audio_out_next = scaled;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      audio_out_reg <= '0;
    end else begin
      audio_out_reg <= audio_out_next;
    end
  end

  assign audio_out = audio_out_reg;

endmodule

// File: tb/tb_team_06_volume_shifter.sv
// Self-checking bench for team_06_volume_shifter: directed corner cases, then random
// stimulus compared against an arithmetic reference model.
module tb_team_06_volume_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] audio_in = '0;
  logic [3:0] volume = '0;
  logic       enable_volume = 1'b0;
  logic [7:0] audio_out;

  int tests = 0;
  int fails = 0;

  team_06_volume_shifter #(.AUDIO_W(8), .VOL_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .audio_in      (audio_in),
    .volume        (volume),
    .enable_volume (enable_volume),
    .audio_out     (audio_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic r, input logic e,
                                       input logic [3:0] v, input logic [7:0] a);
    int p;
    if (r) return 8'd0;
    if (!e) return a;
`ifdef TEAM06_VOLUME_CENTERED_EN
    p = (int'(a) - 128) * (int'(v) + 1);
    return 8'(128 + (p >>> 4));
`else
    p = int'(a) * (int'(v) + 1);
    return 8'(p / 16);
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply one set of inputs, clock once, then compare just after the edge.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [3:0] v, input logic [7:0] a, input logic [7:0] exp);
    rst = r;
    enable_volume = e;
    volume = v;
    audio_in = a;
    @(posedge clk);
    #1;
    $display("[TB] %s rst=%0b en=%0b vol=%0d in=%0d out=%0d exp=%0d",
             tag, r, e, v, a, audio_out, exp);
    check_eq(tag, audio_out, exp);
  endtask

  initial begin
    logic r, e;
    logic [3:0] v;
    logic [7:0] a;
    logic [7:0] exp_v;

    #2;
    step("reset", 1'b1, 1'b1, 4'd15, 8'd255, 8'd0);
    step("reset_hold", 1'b1, 1'b0, 4'd6, 8'd77, 8'd0);
    step("bypass_64", 1'b0, 1'b0, 4'd6, 8'd64, 8'd64);
`ifdef TEAM06_VOLUME_CENTERED_EN
    step("ctr_64_v6", 1'b0, 1'b1, 4'd6, 8'd64, 8'd100);
    step("ctr_0_v8", 1'b0, 1'b1, 4'd8, 8'd0, 8'd56);
    step("ctr_255_v15", 1'b0, 1'b1, 4'd15, 8'd255, 8'd255);
    step("ctr_255_v0", 1'b0, 1'b1, 4'd0, 8'd255, 8'd135);
    step("ctr_128_v3", 1'b0, 1'b1, 4'd3, 8'd128, 8'd128);
    step("ctr_bypass_0", 1'b0, 1'b0, 4'd8, 8'd0, 8'd0);
`else
    step("scale_64_v6", 1'b0, 1'b1, 4'd6, 8'd64, 8'd28);
    step("unity_255", 1'b0, 1'b1, 4'd15, 8'd255, 8'd255);
    step("min_255_v0", 1'b0, 1'b1, 4'd0, 8'd255, 8'd15);
    step("zero_v8", 1'b0, 1'b1, 4'd8, 8'd0, 8'd0);
    step("floor_1_v14", 1'b0, 1'b1, 4'd14, 8'd1, 8'd0);
    step("floor_17_v0", 1'b0, 1'b1, 4'd0, 8'd17, 8'd1);
`endif
    step("stream_a", 1'b0, 1'b1, 4'd15, 8'd255, 8'd255);
    step("stream_b", 1'b0, 1'b1, 4'd15, 8'd255, 8'd255);
    step("mid_rst", 1'b1, 1'b1, 4'd15, 8'd255, 8'd0);
    step("after_rst", 1'b0, 1'b1, 4'd15, 8'd255, 8'd255);
    step("toggle_en0", 1'b0, 1'b0, 4'd15, 8'd255, 8'd255);
    step("toggle_en1", 1'b0, 1'b1, 4'd15, 8'd255, 8'd255);
    step("bypass_100", 1'b0, 1'b0, 4'd3, 8'd100, 8'd100);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) == 0);
      e = 1'($urandom);
      v = 4'($urandom);
      a = 8'($urandom);
      exp_v = model(r, e, v, a);
      step("random", r, e, v, a, exp_v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got %0d checks, expected bench to finish", tests);
    $fatal(1, "timeout");
  end

endmodule
